// File: rtl/rram_io_ctrl.sv
// -----------------------------------------------------------------------------
// rram_io_ctrl
//   Host-side I/O controller for an RRAM array. A NAND-style serial host
//   interface (CLE/ALE/WE/RE strobes, one data bit on io_in) is synchronised
//   into the clk domain. The block decodes command bytes, collects the array
//   address, and sequences the array request/acknowledge handshake for
//   program and read.
//
//   Commands: 0x80 program setup, 0x00 read setup, 0x10 program go,
//             0x30 read go, 0xFF reset (accepted in any state).
//
// Parameters
//   ADDR_W        array address width, shifted in LSB-first
//   DATA_W        data register width (register_add wraps at DATA_W-1)
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   CE            chip deselect; aborts to IDLE synchronously
//   CLE, ALE      command / address latch enables (async, synchronised)
//   WE, RE        host write / read strobes (async, synchronised)
//   io_in         serial host bit, sampled on WE rising edge
//   WE_L, RE_L    data register shift-in / drive-out enables
//   register_add  data register bit index driven during readout
//   arr_req       array access request
//   arr_wr        access direction (1 = program)
//   arr_addr      latched array address
//   arr_ack       single-cycle array completion pulse
//   busy          high while an array access is pending
//   fail          last access was aborted by the watchdog
//
// Build option
//   RRAM_CTRL_TIMEOUT_EN  when defined, an 8-bit watchdog aborts an array
//                         access that has not been acknowledged after 255
//                         cycles and sets fail. Otherwise the controller
//                         waits for arr_ack indefinitely.
// -----------------------------------------------------------------------------
module rram_io_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CE,
  input  logic              CLE,
  input  logic              ALE,
  input  logic              WE,
  input  logic              RE,
  input  logic              io_in,
  output logic              WE_L,
  output logic              RE_L,
  output logic [4:0]        register_add,
  output logic              arr_req,
  output logic              arr_wr,
  output logic [ADDR_W-1:0] arr_addr,
  input  logic              arr_ack,
  output logic              busy,
  output logic              fail
);

  localparam logic [7:0] CMD_READ     = 8'h00;
  localparam logic [7:0] CMD_PROG     = 8'h80;
  localparam logic [7:0] CMD_PROG_GO  = 8'h10;
  localparam logic [7:0] CMD_READ_GO  = 8'h30;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  localparam int         ACNT_W    = $clog2(ADDR_W + 1);
  localparam logic [ACNT_W-1:0] ACNT_LAST = ACNT_W'(ADDR_W - 1);
  localparam logic [ACNT_W-1:0] ACNT_FULL = ACNT_W'(ADDR_W);
  localparam logic [4:0] RA_LAST   = 5'(DATA_W - 1);

  // Bit positions in the synchroniser vectors
  localparam int B_WE  = 0;
  localparam int B_RE  = 1;
  localparam int B_CLE = 2;
  localparam int B_ALE = 3;
  localparam int B_IO  = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    WDATA  = 3'd2,
    PROG   = 3'd3,
    RDWAIT = 3'd4,
    RDATA  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [4:0]          sync1_q, sync1_d;
  logic [4:0]          sync2_q, sync2_d;
  logic [2:0]          prev_q, prev_d;     // previous synced WE/RE/CLE for edges
  logic [6:0]          cmd_q, cmd_d;       // first seven bits of the command byte
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic                arr_wr_q, arr_wr_d;
  logic [ADDR_W-1:0]   arr_addr_q, arr_addr_d;
  logic [ACNT_W-1:0]   acnt_q, acnt_d;
  logic [4:0]          reg_add_q, reg_add_d;
  logic                fail_q, fail_d;

  logic                we_rise, re_fall, cle_fall;
  logic                cle_s, ale_s, io_s;
  logic                cmd_strobe, addr_strobe;
  logic                cmd_fire;
  logic [7:0]          cmd_byte;
  logic                in_access;
  logic                timeout;

  // Synchronised host signals and edge detection
  assign cle_s       = sync2_q[B_CLE];
  assign ale_s       = sync2_q[B_ALE];
  assign io_s        = sync2_q[B_IO];
  assign we_rise     =  sync2_q[B_WE]  & ~prev_q[B_WE];
  assign re_fall     = ~sync2_q[B_RE]  &  prev_q[B_RE];
  assign cle_fall    = ~sync2_q[B_CLE] &  prev_q[B_CLE];
  assign cmd_strobe  = we_rise &  cle_s & ~ale_s;
  assign addr_strobe = we_rise &  ale_s & ~cle_s;
  assign in_access   = (state_q == PROG) || (state_q == RDWAIT);

  always_comb begin
    sync1_d = {io_in, ALE, CLE, RE, WE};
    sync2_d = sync1_q;
    prev_d  = sync2_q[2:0];
  end

  // Command byte assembly: LSB first, a command fires on the eighth bit
  always_comb begin
    cmd_d     = cmd_q;
    bit_cnt_d = bit_cnt_q;
    cmd_fire  = 1'b0;
    cmd_byte  = {io_s, cmd_q};
    if (CE || cle_fall) begin
      bit_cnt_d = '0;
    end else if (cmd_strobe) begin
      cmd_d     = cmd_byte[7:1];
      bit_cnt_d = bit_cnt_q + 3'd1;
      cmd_fire  = (bit_cnt_q == 3'd7);
    end
  end

`ifdef RRAM_CTRL_TIMEOUT_EN
  localparam logic [7:0] WDOG_LIMIT = 8'd254;  // cycle 255 of the access
  logic [7:0] wdog_q, wdog_d;

  always_comb begin
    wdog_d  = '0;
    timeout = 1'b0;
    if (in_access) begin
      wdog_d  = wdog_q + 8'd1;
      timeout = (wdog_q == WDOG_LIMIT) && !arr_ack;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wdog_q <= '0;
    else        wdog_q <= wdog_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state logic. Abort sources take priority: CE, then reset command,
  // then the watchdog.
  always_comb begin
    state_d    = state_q;
    arr_wr_d   = arr_wr_q;
    arr_addr_d = arr_addr_q;
    acnt_d     = acnt_q;
    reg_add_d  = reg_add_q;
    fail_d     = fail_q;
    if (CE) begin
      state_d = IDLE;
      acnt_d  = '0;
    end else if (cmd_fire && (cmd_byte == CMD_RESET)) begin
      state_d   = IDLE;
      acnt_d    = '0;
      reg_add_d = '0;
      fail_d    = 1'b0;
    end else if (timeout) begin
      state_d = IDLE;
      fail_d  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_fire && (cmd_byte == CMD_PROG)) begin
            state_d  = ADDR;
            arr_wr_d = 1'b1;
            acnt_d   = '0;
          end else if (cmd_fire && (cmd_byte == CMD_READ)) begin
            state_d  = ADDR;
            arr_wr_d = 1'b0;
            acnt_d   = '0;
          end
        end
        ADDR: begin
          // Bits beyond ADDR_W are dropped once the counter saturates
          if (addr_strobe && (acnt_q != ACNT_FULL)) begin
            arr_addr_d = {io_s, arr_addr_q[ADDR_W-1:1]};
            acnt_d     = acnt_q + 1'b1;
            if ((acnt_q == ACNT_LAST) && arr_wr_q) state_d = WDATA;
          end else if (cmd_fire && (cmd_byte == CMD_READ_GO) &&
                       !arr_wr_q && (acnt_q == ACNT_FULL)) begin
            state_d = RDWAIT;
          end
        end
        WDATA: begin
          if (cmd_fire && (cmd_byte == CMD_PROG_GO)) state_d = PROG;
        end
        PROG: begin
          if (arr_ack) state_d = IDLE;
        end
        RDWAIT: begin
          if (arr_ack) begin
            state_d   = RDATA;
            reg_add_d = '0;
          end
        end
        RDATA: begin
          if (cmd_fire) begin
            state_d = IDLE;
          end else if (re_fall) begin
            reg_add_d = (reg_add_q == RA_LAST) ? 5'd0 : reg_add_q + 5'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      cmd_q      <= '0;
      bit_cnt_q  <= '0;
      arr_wr_q   <= 1'b0;
      arr_addr_q <= '0;
      acnt_q     <= '0;
      reg_add_q  <= '0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      cmd_q      <= cmd_d;
      bit_cnt_q  <= bit_cnt_d;
      arr_wr_q   <= arr_wr_d;
      arr_addr_q <= arr_addr_d;
      acnt_q     <= acnt_d;
      reg_add_q  <= reg_add_d;
      fail_q     <= fail_d;
    end
  end

  // Outputs decode directly from registered state so reset clears them at once
  assign WE_L         = (state_q == WDATA);
  assign RE_L         = (state_q == RDATA);
  assign arr_req      = in_access;
  assign busy         = in_access;
  assign arr_wr       = arr_wr_q;
  assign arr_addr     = arr_addr_q;
  assign register_add = reg_add_q;
  assign fail         = fail_q;

endmodule

// File: tb/tb_rram_io_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rram_io_ctrl
//   Scoreboard bench for rram_io_ctrl: expected values are queued as host
//   stimulus is driven and compared when the controller responds.
// -----------------------------------------------------------------------------
module tb_rram_io_ctrl;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              CE, CLE, ALE, WE, RE, io_in;
  logic              WE_L, RE_L;
  logic [4:0]        register_add;
  logic              arr_req, arr_wr;
  logic [ADDR_W-1:0] arr_addr;
  logic              arr_ack;
  logic              busy, fail;

  int n_tests = 0;
  int n_fail  = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  rram_io_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .CE(CE), .CLE(CLE), .ALE(ALE),
    .WE(WE), .RE(RE), .io_in(io_in),
    .WE_L(WE_L), .RE_L(RE_L), .register_add(register_add),
    .arr_req(arr_req), .arr_wr(arr_wr), .arr_addr(arr_addr),
    .arr_ack(arr_ack), .busy(busy), .fail(fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic sb_pop_chk(input logic [31:0] act);
    string       t;
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      chk(t, act, e);
    end
  endtask

  function automatic logic [31:0] st(input logic f, input logic b, input logic r,
                                     input logic w, input logic wl, input logic rl,
                                     input logic [15:0] a);
    return {10'd0, f, b, r, w, wl, rl, a};
  endfunction

  function automatic logic [31:0] cur();
    return {10'd0, fail, busy, arr_req, arr_wr, WE_L, RE_L, arr_addr};
  endfunction

  // Advance n clocks, then sit 1ns past the edge for driving and sampling
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic we_pulse(input logic b);
    io_in = b;
    cyc(2);
    WE = 1'b1;
    cyc(3);
    WE = 1'b0;
    cyc(3);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    CLE = 1'b1;
    cyc(2);
    for (int i = 0; i < 8; i++) we_pulse(c[i]);
    CLE = 1'b0;
    cyc(4);
  endtask

  task automatic send_addr(input logic [31:0] a, input int nbits);
    ALE = 1'b1;
    cyc(2);
    for (int i = 0; i < nbits; i++) we_pulse(a[i]);
    ALE = 1'b0;
    cyc(4);
  endtask

  task automatic send_data(input int nbits);
    for (int i = 0; i < nbits; i++) we_pulse(1'($urandom_range(0, 1)));
  endtask

  task automatic re_pulse();
    RE = 1'b1;
    cyc(3);
    RE = 1'b0;
    cyc(4);
  endtask

  task automatic ack_pulse();
    arr_ack = 1'b1;
    cyc(1);
    arr_ack = 1'b0;
  endtask

  task automatic wait_req(input logic want);
    int n;
    n = 0;
    while ((arr_req !== want) && (n < 40)) begin
      cyc(1);
      n++;
    end
  endtask

  initial begin
    rst_n = 1'b0; CE = 1'b0; CLE = 1'b0; ALE = 1'b0;
    WE = 1'b0; RE = 1'b0; io_in = 1'b0; arr_ack = 1'b0;
    cyc(3);
    sb_push("reset_status", st(0, 0, 0, 0, 0, 0, 16'h0000));
    sb_pop_chk(cur());
    sb_push("reset_regadd", 32'd0);
    sb_pop_chk(32'(register_add));
    rst_n = 1'b1;
    cyc(2);

    // Program 0x1234
    send_cmd(8'h80);
    sb_push("prog_setup", st(0, 0, 0, 1, 0, 0, 16'h0000));
    sb_pop_chk(cur());
    send_addr(32'h1234, 16);
    sb_push("prog_wdata", st(0, 0, 0, 1, 1, 0, 16'h1234));
    sb_pop_chk(cur());
    send_data(32);
    send_cmd(8'h10);
    sb_push("prog_req", st(0, 1, 1, 1, 0, 0, 16'h1234));
    wait_req(1'b1);
    sb_pop_chk(cur());
    ack_pulse();
    cyc(2);
    sb_push("prog_done", st(0, 0, 0, 1, 0, 0, 16'h1234));
    sb_pop_chk(cur());

    // Read 0x00FF, with four surplus address bits that must be dropped
    send_cmd(8'h00);
    sb_push("read_setup", st(0, 0, 0, 0, 0, 0, 16'h1234));
    sb_pop_chk(cur());
    send_addr(32'h000F_00FF, 20);
    sb_push("read_addr", st(0, 0, 0, 0, 0, 0, 16'h00FF));
    sb_pop_chk(cur());
    send_cmd(8'h30);
    sb_push("read_req", st(0, 1, 1, 0, 0, 0, 16'h00FF));
    wait_req(1'b1);
    sb_pop_chk(cur());
    ack_pulse();
    cyc(2);
    sb_push("rdata_status", st(0, 0, 0, 0, 0, 1, 16'h00FF));
    sb_push("rdata_entry_ra", 32'd0);
    sb_pop_chk(cur());
    sb_pop_chk(32'(register_add));
    for (int k = 1; k <= 33; k++) begin
      re_pulse();
      sb_push($sformatf("ra_step%0d", k), 32'(k % DATA_W));
      sb_pop_chk(32'(register_add));
    end

    // Asynchronous reset in RDATA, checked before any further clock edge
    #3;
    rst_n = 1'b0;
    #1;
    sb_push("async_rst_status", st(0, 0, 0, 0, 0, 0, 16'h0000));
    sb_push("async_rst_ra", 32'd0);
    sb_pop_chk(cur());
    sb_pop_chk(32'(register_add));
    cyc(1);
    rst_n = 1'b1;
    cyc(2);

    // Any command byte leaves RDATA
    send_cmd(8'h00);
    send_addr(32'h0042, 16);
    send_cmd(8'h30);
    wait_req(1'b1);
    ack_pulse();
    cyc(2);
    sb_push("rdata2_status", st(0, 0, 0, 0, 0, 1, 16'h0042));
    sb_pop_chk(cur());
    send_cmd(8'h5A);
    sb_push("rdata_exit", st(0, 0, 0, 0, 0, 0, 16'h0042));
    sb_pop_chk(cur());

    // 0xFF during PROG, then a late ack and a stray 0x10 are ignored
    send_cmd(8'h80);
    send_addr(32'h0A5C, 16);
    send_cmd(8'h10);
    sb_push("ff_prog_req", st(0, 1, 1, 1, 0, 0, 16'h0A5C));
    wait_req(1'b1);
    sb_pop_chk(cur());
    send_cmd(8'hFF);
    sb_push("ff_abort", st(0, 0, 0, 1, 0, 0, 16'h0A5C));
    sb_pop_chk(cur());
    ack_pulse();
    cyc(2);
    sb_push("late_ack", st(0, 0, 0, 1, 0, 0, 16'h0A5C));
    sb_pop_chk(cur());
    send_cmd(8'h10);
    sb_push("idle_go_ignored", st(0, 0, 0, 1, 0, 0, 16'h0A5C));
    sb_pop_chk(cur());

    // CE abort: arr_req drops on the following cycle, address held
    send_cmd(8'h80);
    send_addr(32'h5A5A, 16);
    send_cmd(8'h10);
    wait_req(1'b1);
    CE = 1'b1;
    cyc(1);
    sb_push("ce_abort", st(0, 0, 0, 1, 0, 0, 16'h5A5A));
    sb_pop_chk(cur());
    CE = 1'b0;
    cyc(2);

    // Unacknowledged access
    send_cmd(8'h80);
    send_addr(32'h0003, 16);
    send_cmd(8'h10);
    wait_req(1'b1);
`ifdef RRAM_CTRL_TIMEOUT_EN
    cyc(200);
    sb_push("wdog_pending", st(0, 1, 1, 1, 0, 0, 16'h0003));
    sb_pop_chk(cur());
    cyc(70);
    sb_push("wdog_expired", st(1, 0, 0, 1, 0, 0, 16'h0003));
    sb_pop_chk(cur());
    send_cmd(8'hFF);
    sb_push("fail_cleared", st(0, 0, 0, 1, 0, 0, 16'h0003));
    sb_pop_chk(cur());
`else
    cyc(1000);
    sb_push("no_timeout", st(0, 1, 1, 1, 0, 0, 16'h0003));
    sb_pop_chk(cur());
    send_cmd(8'hFF);
    sb_push("no_timeout_ff", st(0, 0, 0, 1, 0, 0, 16'h0003));
    sb_pop_chk(cur());
`endif

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rram_io_ctrl.md
RRAM_IO_CTRL -- requirements
Module: rram_io_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: array address width, shifted serially.
REQ-002 SHALL have parameter DATA_W, default 32: data register width; register_add is 5 bits for 32.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port CE  input  1  chip deselect, active high.
REQ-006 SHALL have ports CLE, ALE  input  1 each  command and address latch enables.
REQ-007 SHALL have ports WE, RE  input  1 each  host strobes, asynchronous to clk.
REQ-008 SHALL have port io_in  input  1  serial host bit, sampled with WE.
REQ-009 SHALL have ports WE_L, RE_L  output  1 each  data register shift-in and drive-out enables.
REQ-010 SHALL have port register_add  output  5  bit index of the data register driven on readout.
REQ-011 SHALL have ports arr_req, arr_wr  output  1 each  array access request and direction (1 = program).
REQ-012 SHALL have port arr_addr  output  ADDR_W  latched array address.
REQ-013 SHALL have port arr_ack  input  1  single-cycle array completion pulse.
REQ-014 SHALL have port busy  output  1  ready/busy; high while an array access is pending.
REQ-015 SHALL have port fail  output  1  status: last access aborted.

Function
REQ-016 SHALL pass WE, RE, CLE, ALE and io_in through two-flop synchronisers; all edges are detected on synchronised values.
REQ-017 SHALL shift io_in LSB-first into an 8-bit command register on each WE rising edge while CLE=1, ALE=0.
REQ-018 SHALL act on a command only on the 8th bit; the bit counter clears when CLE falls.
REQ-019 SHALL use FSM states IDLE, ADDR, WDATA, PROG, RDWAIT, RDATA.
REQ-020 SHALL move IDLE->ADDR on 0x80 (arr_wr=1) or 0x00 (arr_wr=0); other codes except 0xFF are ignored.
REQ-021 SHALL in ADDR shift ADDR_W bits LSB-first into arr_addr on WE rising edges with ALE=1, CLE=0; extra bits are discarded.
REQ-022 SHALL move ADDR->WDATA after the last address bit when arr_wr=1, driving WE_L=1 in WDATA.
REQ-023 SHALL move WDATA->PROG on command 0x10; ADDR->RDWAIT on 0x30 with a complete address, otherwise stay.
REQ-024 SHALL assert arr_req and busy from the cycle after entering PROG/RDWAIT until the cycle arr_ack is sampled.
REQ-025 SHALL move PROG->IDLE and RDWAIT->RDATA on arr_ack.
REQ-026 SHALL drive RE_L=1 in RDATA and increment register_add by 1 on each RE falling edge, wrapping 31->0.
REQ-027 SHALL leave RDATA for IDLE on any command byte; register_add resets to 0 on RDATA entry.
REQ-028 SHALL on 0xFF in any state return to IDLE and clear arr_req, counters and fail, even mid-access.
REQ-029 SHALL treat CE=1 as synchronous abort to IDLE; arr_req drops the next cycle; arr_addr is held.
REQ-030 SHALL ignore arr_ack outside PROG/RDWAIT.

Reset
REQ-031 SHALL on rst_n=0 asynchronously force state IDLE, WE_L=0, RE_L=0, register_add=0, arr_req=0, arr_wr=0, arr_addr=0, busy=0, fail=0 and all counters and synchronisers to 0.

Configuration
REQ-032 SHALL when RRAM_CTRL_TIMEOUT_EN is defined run an 8-bit watchdog in PROG/RDWAIT; after 255 cycles without arr_ack it drops arr_req, sets fail=1 and returns to IDLE.
REQ-033 SHALL when RRAM_CTRL_TIMEOUT_EN is undefined wait for arr_ack indefinitely; fail stays 0.

Verification
REQ-034 SHALL cover program: 0x80, address 0x1234, 32 data bits, 0x10 -> arr_req=1, arr_wr=1, arr_addr=0x1234; ack -> IDLE, busy=0.
REQ-035 SHALL cover read: 0x00, address 0x00FF, 0x30, ack -> RE_L=1; 33 RE falls -> register_add steps 1..31,0,1.
REQ-036 SHALL cover 0xFF during PROG before ack -> arr_req=0 next cycle, state IDLE, late ack ignored.
REQ-037 SHALL cover rst_n low mid-RDATA -> all outputs at reset values immediately, without clk.
REQ-038 SHALL cover timeout build: PROG with no ack for 255 cycles -> fail=1, arr_req=0; non-timeout build -> arr_req still 1 after 1000 cycles.
